approx_mult_pipe: RTL and testbench



---
 rtl/approx_mult_pkg.sv | 32 +++
 rtl/approx_csa_tree.sv | 31 +++
 rtl/approx_mult_pipe.sv | 116 +++++++++++
 tb/tb_approx_mult_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared sizing helpers and a bit-level reference model for the approximate multiplier.
package approx_mult_pkg;

    function automatic int unsigned calc_kw(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned n);
        return (k > 2 * n) ? 2 * n : k;
    endfunction

    // Columns below keff are ORed, everything at or above keff is summed exactly.
    function automatic logic [63:0] approx_mul_ref(input logic [31:0] a, input logic [31:0] b,
                                                   input int unsigned k, input int unsigned n);
        int unsigned keff;
        logic [63:0] upper;
        logic [63:0] lower;
        keff  = clamp_k(k, n);
        upper = '0;
        lower = '0;
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned j = 0; j < n; j++) begin
                if (a[i] && b[j]) begin
                    if (i + j >= keff) upper = upper + (64'd1 << (i + j));
                    else               lower[i + j] = 1'b1;
                end
            end
        end
        return upper | lower;
    endfunction

endpackage

// File: rtl/approx_csa_tree.sv
// Carry-save reduction of N shifted partial-product rows into a sum/carry pair.
module approx_csa_tree #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0][2*N-1:0] rows_i,
    output logic [2*N-1:0]        sum_o,
    output logic [2*N-1:0]        carry_o
);
    localparam int unsigned PW = 2 * N;

    logic [N-1:0][PW-1:0] s_acc;
    logic [N-1:0][PW-1:0] c_acc;
    logic [N-1:0][PW-1:0] maj;

    assign s_acc[0] = rows_i[0];
    assign c_acc[0] = '0;
    assign maj[0]   = '0;

    // Each step is a row of exact full adders folding one more row into the pair.
    // Dropping the carry out of the top column is safe: the true total fits in 2N bits.
    for (genvar j = 1; j < N; j++) begin : g_csa
        assign s_acc[j] = s_acc[j-1] ^ c_acc[j-1] ^ rows_i[j];
        assign maj[j]   = (s_acc[j-1] & c_acc[j-1]) | (s_acc[j-1] & rows_i[j]) |
                          (c_acc[j-1] & rows_i[j]);
        assign c_acc[j] = {maj[j][PW-2:0], 1'b0};
    end

    assign sum_o   = s_acc[N-1];
    assign carry_o = c_acc[N-1];

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage streaming N x N multiplier with per-transaction lower-part-OR approximation depth.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned KW    = calc_kw(N),
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [KW-1:0]    in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic [KW-1:0]    out_k,
    output logic [CNT_W-1:0] approx_cnt
);
    localparam int unsigned PW = 2 * N;

    logic             s0_valid_q, s1_valid_q, s2_valid_q;
    logic [N-1:0]     s0_a_q, s0_b_q;
    logic [KW-1:0]    s0_k_q, s1_k_q, s2_k_q;
    logic [PW-1:0]    s1_sum_q, s1_carry_q, s1_lower_q;
    logic [PW-1:0]    s2_p_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s0_en, s1_en, s2_en, out_xfer;
    logic [KW-1:0]    keff_d;
    logic [PW-1:0]    upper_mask, lower_or, lower_d, p_d, csa_sum, csa_carry;
    logic [N-1:0][PW-1:0] rows_raw, rows_up;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign s0_en    = !s0_valid_q || s1_en;
    assign in_ready = s0_en;
    assign out_xfer = s2_valid_q && out_ready;

    assign keff_d = KW'(clamp_k(32'(in_k), N));

    always_comb begin
        upper_mask = {PW{1'b1}} << s0_k_q;
        lower_or   = '0;
        for (int j = 0; j < N; j++) begin
            rows_raw[j] = s0_b_q[j] ? (PW'(s0_a_q) << j) : '0;
            rows_up[j]  = rows_raw[j] & upper_mask;
            lower_or    = lower_or | rows_raw[j];
        end
        lower_d = lower_or & ~upper_mask;
    end

    approx_csa_tree #(
        .N (N)
    ) u_csa_tree (
        .rows_i  (rows_up),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    // Upper part is zero below keff, so OR-ing in the lower vector is a plain merge.
    assign p_d = (s1_sum_q + s1_carry_q) | s1_lower_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_k_q     <= '0;
            s1_k_q     <= '0;
            s2_k_q     <= '0;
            s1_sum_q   <= '0;
            s1_carry_q <= '0;
            s1_lower_q <= '0;
            s2_p_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (s0_en) begin
                s0_valid_q <= in_valid;
                if (in_valid) begin
                    s0_a_q <= in_a;
                    s0_b_q <= in_b;
                    s0_k_q <= keff_d;
                end
            end
            if (s1_en) begin
                s1_valid_q <= s0_valid_q;
                if (s0_valid_q) begin
                    s1_sum_q   <= csa_sum;
                    s1_carry_q <= csa_carry;
                    s1_lower_q <= lower_d;
                    s1_k_q     <= s0_k_q;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_p_q <= p_d;
                    s2_k_q <= s1_k_q;
                end
            end
            if (out_xfer && (s2_k_q != '0)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_p      = s2_p_q;
    assign out_k      = s2_k_q;
    assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed and streaming checks of approx_mult_pipe at N=8, plus an exhaustive sweep at N=4.
module tb_approx_mult_pipe;
    import approx_mult_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned KW  = calc_kw(N);
    localparam int unsigned N4  = 4;
    localparam int unsigned KW4 = calc_kw(N4);

    logic          clk;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]  in_a, in_b;
    logic [KW-1:0] in_k, out_k;
    logic [2*N-1:0] out_p;
    logic [31:0]   approx_cnt;

    logic           in_valid4, in_ready4, out_valid4, out_ready4;
    logic [N4-1:0]  in_a4, in_b4;
    logic [KW4-1:0] in_k4, out_k4;
    logic [2*N4-1:0] out_p4;
    logic [31:0]    approx_cnt4;

    int n_pass = 0;
    int n_total = 0;
    int exp_cnt = 0;

    approx_mult_pipe #(.N(N), .KW(KW), .CNT_W(32)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_k       (in_k),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_k      (out_k),
        .approx_cnt (approx_cnt)
    );

    approx_mult_pipe #(.N(N4), .KW(KW4), .CNT_W(32)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_a       (in_a4),
        .in_b       (in_b4),
        .in_k       (in_k4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_p      (out_p4),
        .out_k      (out_k4),
        .approx_cnt (approx_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [4:0]  k;
        logic [15:0] p;
        logic [4:0]  ko;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // One isolated transaction: checks acceptance, latency, result, and counter after transfer.
    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_k = v.k; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("vec in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; got = 0;
        while (lat < 20 && !got) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1;
        end
        chk("vec latency", 64'(lat), 64'd3);
        chk("vec out_p", 64'(out_p), 64'(v.p));
        chk("vec out_k", 64'(out_k), 64'(v.ko));
        if (v.ko != 0) exp_cnt++;
        @(negedge clk);
        chk("vec approx_cnt", 64'(approx_cnt), 64'(exp_cnt));
        chk("vec drained", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        logic [63:0] q_p[$];
        logic [4:0]  q_k[$];
        logic [63:0] e_p;
        logic [4:0]  e_k;
        logic [15:0] held_p;
        logic [4:0]  held_k;
        int sent, rcvd, inflight, first_c, last_c, ghost;
        bit pending, stall_prev, acc, xfer;

        vecs[0]  = '{8'd255, 8'd255, 5'd0,  16'd65025, 5'd0};
        vecs[1]  = '{8'd255, 8'd255, 5'd6,  16'd64767, 5'd6};
        vecs[2]  = '{8'd3,   8'd3,   5'd2,  16'd7,     5'd2};
        vecs[3]  = '{8'd3,   8'd3,   5'd31, 16'd7,     5'd16};
        vecs[4]  = '{8'd7,   8'd5,   5'd3,  16'd31,    5'd3};
        vecs[5]  = '{8'd15,  8'd15,  5'd16, 16'd127,   5'd16};
        vecs[6]  = '{8'd128, 8'd128, 5'd16, 16'd16384, 5'd16};
        vecs[7]  = '{8'd200, 8'd100, 5'd0,  16'd20000, 5'd0};
        vecs[8]  = '{8'd0,   8'd173, 5'd5,  16'd0,     5'd5};
        vecs[9]  = '{8'd255, 8'd1,   5'd17, 16'd255,   5'd16};
        vecs[10] = '{8'd255, 8'd255, 5'd16, 16'd32767, 5'd16};
        vecs[11] = '{8'd170, 8'd85,  5'd8,  16'd13994, 5'd8};
        vecs[12] = '{8'd1,   8'd1,   5'd0,  16'd1,     5'd0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_k = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_k4 = '0; out_ready4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_p", 64'(out_p), 64'd0);
        chk("reset out_k", 64'(out_k), 64'd0);
        chk("reset approx_cnt", 64'(approx_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
            if (i == 0) chk("exact keeps cnt 0", 64'(approx_cnt), 64'd0);
        end

        // Streaming with random backpressure.
        sent = 0; rcvd = 0; inflight = 0; pending = 0; stall_prev = 0;
        held_p = '0; held_k = '0;
        for (int cyc = 0; cyc < 600 && rcvd < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (!pending && sent < 20) begin
                in_a = 8'($urandom); in_b = 8'($urandom); in_k = 5'($urandom_range(0, 31));
                pending = 1;
            end
            in_valid = pending;
            #1;
            if (stall_prev) begin
                chk("stall out_valid", 64'(out_valid), 64'd1);
                chk("stall out_p", 64'(out_p), 64'(held_p));
                chk("stall out_k", 64'(out_k), 64'(held_k));
            end
            chk("stream in_ready", 64'(in_ready), 64'(!(inflight == 3 && !out_ready)));
            xfer = out_valid && out_ready;
            acc  = in_valid && in_ready;
            if (xfer) begin
                if (q_p.size() == 0) begin
                    chk("stream extra output", 64'd1, 64'd0);
                end else begin
                    e_p = q_p.pop_front();
                    e_k = q_k.pop_front();
                    chk("stream out_p", 64'(out_p), e_p);
                    chk("stream out_k", 64'(out_k), 64'(e_k));
                    if (e_k != 0) exp_cnt++;
                end
                rcvd++;
            end
            stall_prev = out_valid && !out_ready;
            held_p = out_p;
            held_k = out_k;
            if (acc) begin
                q_p.push_back(approx_mul_ref(32'(in_a), 32'(in_b), 32'(in_k), N));
                q_k.push_back(5'(clamp_k(32'(in_k), N)));
                sent++;
                pending = 0;
            end
            inflight = inflight + int'(acc) - int'(xfer);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream count", 64'(rcvd), 64'd20);
        chk("stream approx_cnt", 64'(approx_cnt), 64'(exp_cnt));

        // Fill all three stages under backpressure, then reset mid-flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = 8'(i + 9); in_b = 8'd11; in_k = 5'd4; in_valid = 1'b1;
            #1 chk("fill in_ready", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("full out_valid", 64'(out_valid), 64'd1);
        chk("full in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset approx_cnt", 64'(approx_cnt), 64'd0);
        out_ready = 1'b1;
        ghost = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        chk("no ghost outputs", 64'(ghost), 64'd0);
        run_vec(vecs[1]);

        // Continuous full-rate stream with k=1.
        do_reset();
        q_p.delete(); q_k.delete();
        sent = 0; rcvd = 0; first_c = -1; last_c = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 150 && rcvd < 100; cyc++) begin
            @(negedge clk);
            if (sent < 100) begin
                in_a = 8'(sent); in_b = 8'(sent * 7 + 3); in_k = 5'd1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                e_p = (q_p.size() != 0) ? q_p.pop_front() : 64'hdead;
                e_k = (q_k.size() != 0) ? q_k.pop_front() : 5'd0;
                chk("burst out_p", 64'(out_p), e_p);
                chk("burst out_k", 64'(out_k), 64'(e_k));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q_p.push_back(approx_mul_ref(32'(in_a), 32'(in_b), 1, N));
                q_k.push_back(5'd1);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("burst count", 64'(rcvd), 64'd100);
        chk("burst one per cycle", 64'(last_c - first_c), 64'd99);
        chk("burst approx_cnt", 64'(approx_cnt), 64'd100);

        // Exhaustive N=4 sweep over a, b and every encodable k.
        q_p.delete();
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 4200 && rcvd < 4096; cyc++) begin
            @(negedge clk);
            if (out_valid4) begin
                e_p = (q_p.size() != 0) ? q_p.pop_front() : 64'hdead;
                chk("n4 out_p", 64'(out_p4), e_p);
                rcvd++;
            end
            if (sent < 4096) begin
                in_a4 = 4'(sent); in_b4 = 4'(sent >> 4); in_k4 = 4'(sent >> 8); in_valid4 = 1'b1;
            end else begin
                in_valid4 = 1'b0;
            end
            #1;
            if (in_valid4 && in_ready4) begin
                q_p.push_back(approx_mul_ref(32'(in_a4), 32'(in_b4), 32'(in_k4), N4));
                sent++;
            end
        end
        in_valid4 = 1'b0;
        chk("n4 count", 64'(rcvd), 64'd4096);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
